led_chaser: RTL

Parametrised LED pattern generator for the board LED bank, driven directly from the 50 MHz system clock. A fully synchronous prescaler produces a step tick that advances a pattern position. The position is decoded into one of four display patterns: rotate, bounce, fill bar and blink. The block sits between the top-level switch/mode inputs and the `led` output pins. It replaces the fixed 10-LED single-dot chaser.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_chaser_if.sv | 29 ++
 rtl/led_tick_gen.sv | 32 +++
 rtl/led_chaser.sv | 130 +++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode encoding and shared widths for the LED chaser
package led_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

endpackage

// File: rtl/led_chaser_if.sv
// rtl/led_chaser_if.sv - control inputs and LED outputs of the chaser as one bundle
interface led_chaser_if
    import led_pkg::*;
#(
    parameter int N_LEDS = 10
) ();

    localparam int POS_W = $clog2(N_LEDS);

    logic               enable;
    mode_t              mode;
    logic               dir;
    logic [SPEED_W-1:0] speed;
    logic [N_LEDS-1:0]  led;
    logic [POS_W-1:0]   pos;
    logic               step;
    logic               wrap;

    modport master (
        output enable, mode, dir, speed,
        input  led, pos, step, wrap
    );

    modport slave (
        input  enable, mode, dir, speed,
        output led, pos, step, wrap
    );

endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler with a speed-selectable step tick
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_W = 14
) (
    input  logic               clk_50M,
    input  logic               reset,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    input  logic               clear,
    output logic               tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] mask;

    // Faster speeds look at fewer low bits, so the counter never needs a reload.
    assign mask = {DIV_W{1'b1}} >> speed;
    assign tick = ((cnt_q & mask) == mask);

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - LED pattern generator: rotate, bounce, fill bar and blink
module led_chaser
    import led_pkg::*;
#(
    parameter int N_LEDS = 10,
    parameter int DIV_W  = 14
) (
    input logic         clk_50M,
    input logic         reset,
    led_chaser_if.slave bus
);

    localparam int               POS_W    = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [1:0] rst_sync_q;
    logic       rst_i;

    // Assert immediately, release two clocks after the external reset drops.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_i = rst_sync_q[1];

    logic              tick;
    logic              clear;
    logic [POS_W-1:0]  pos_q,  pos_d;
    logic              up_q,   up_d;
    logic              phase_q, phase_d;
    mode_t             mode_q, mode_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic [N_LEDS-1:0] led_q,  led_d;

    led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk_50M (clk_50M),
        .reset   (rst_i),
        .enable  (bus.enable),
        .speed   (bus.speed),
        .clear   (clear),
        .tick    (tick)
    );

    always_ff @(posedge clk_50M or posedge rst_i) begin
        if (rst_i) begin
            pos_q   <= '0;
            up_q    <= 1'b1;
            phase_q <= 1'b0;
            mode_q  <= MODE_ROTATE;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            pos_q   <= pos_d;
            up_q    <= up_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        pos_d   = pos_q;
        up_d    = up_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        clear   = 1'b0;
        if (bus.mode != mode_q) begin
            // A new pattern always starts from a clean position and a full period.
            mode_d  = bus.mode;
            pos_d   = '0;
            up_d    = 1'b1;
            phase_d = 1'b0;
            clear   = 1'b1;
        end else if (bus.enable && tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_BOUNCE: begin
                    pos_d = up_q ? pos_q + POS_ONE : pos_q - POS_ONE;
                    if ((up_q && pos_d == POS_LAST) || (!up_q && pos_d == '0)) begin
                        up_d   = ~up_q;
                        wrap_d = 1'b1;
                    end
                end
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                    wrap_d  = phase_q;
                end
                default: begin
                    if (!bus.dir) begin
                        wrap_d = (pos_q == POS_LAST);
                        pos_d  = wrap_d ? '0 : pos_q + POS_ONE;
                    end else begin
                        wrap_d = (pos_q == '0);
                        pos_d  = wrap_d ? POS_LAST : pos_q - POS_ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_FILL: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    led_d[i] = (POS_W'(i) <= pos_q);
                end
            end
            MODE_BLINK: led_d = {N_LEDS{phase_q}};
            default:    led_d[pos_q] = 1'b1;
        endcase
    end

    assign bus.led  = led_q;
    assign bus.pos  = pos_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule
